eeprom_master: RTL



---
 rtl/eeprom_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/eeprom_master.sv
// rtl/eeprom_master.sv - byte-level two-wire master for the save EEPROM (ce/data_in/data_out).
// Optional EEPROM_MASTER_ACK_CHECK_EN: a NACK in any address/data ACK cell sets ack_err and aborts to STOP.
module eeprom_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [12:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_out,
  input  logic        sda_in
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, TX_BYTE, TX_ACK, RSTART, RX_BYTE, RX_NACK, STOP
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [1:0]    qtr_q;
  logic [3:0]    bit_q;
  logic [2:0]    idx_q;
  logic [7:0]    tx_q, rx_q, rdata_q, wdata_q;
  logic [12:0]   addr_q;
  logic          we_q, busy_q, done_q, scl_q, sda_q, ack_err_q;
  logic          cell_end, sample, scl_d, sda_d, nack_stop;

  // Pins are registered from the current position, so they trail the state by one clock;
  // sampling at the first clock of Q2 therefore lands on the last clock of Q1 on the wire.
  always_comb begin
    cell_end = (div_q == DIV_MAX) && (qtr_q == 2'd3);
    sample   = (div_q == '0) && (qtr_q == 2'd2);
    scl_d    = 1'b1;
    sda_d    = 1'b1;
    case (state_q)
      START, RSTART: begin
        scl_d = qtr_q[1] ^ qtr_q[0];
        sda_d = ~qtr_q[1];
      end
      TX_BYTE: begin
        scl_d = qtr_q[1] ^ qtr_q[0];
        sda_d = tx_q[7];
      end
      TX_ACK, RX_BYTE, RX_NACK: scl_d = qtr_q[1] ^ qtr_q[0];
      STOP: begin
        scl_d = (qtr_q != 2'd0);
        sda_d = qtr_q[1];
      end
      default: ;
    endcase
`ifdef EEPROM_MASTER_ACK_CHECK_EN
    nack_stop = ack_err_q;
`else
    nack_stop = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      ack_err_q <= 1'b0;
    end else begin
      scl_q  <= scl_d;
      sda_q  <= sda_d;
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        div_q <= '0;
        qtr_q <= '0;
        // Busy while idle means STOP just finished: this is the completion cycle.
        if (busy_q) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (!we_q) rdata_q <= rx_q;
        end else if (req) begin
          busy_q    <= 1'b1;
          we_q      <= we;
          addr_q    <= addr;
          wdata_q   <= wdata;
          ack_err_q <= 1'b0;
          state_q   <= START;
        end
      end else begin
        if (div_q == DIV_MAX) begin
          div_q <= '0;
          qtr_q <= qtr_q + 2'd1;
        end else begin
          div_q <= div_q + DW'(1);
        end
        if (sample && state_q == RX_BYTE) rx_q <= {rx_q[6:0], sda_in};
`ifdef EEPROM_MASTER_ACK_CHECK_EN
        if (sample && state_q == TX_ACK && sda_in) ack_err_q <= 1'b1;
`endif
        if (cell_end) begin
          case (state_q)
            START: begin
              state_q <= TX_BYTE;
              tx_q    <= 8'hA0;
              idx_q   <= 3'd0;
              bit_q   <= 4'd0;
            end
            TX_BYTE: begin
              tx_q  <= {tx_q[6:0], 1'b0};
              bit_q <= bit_q + 4'd1;
              if (bit_q == 4'd7) state_q <= TX_ACK;
            end
            TX_ACK: begin
              bit_q   <= 4'd0;
              idx_q   <= idx_q + 3'd1;
              state_q <= TX_BYTE;
              if (nack_stop) begin
                state_q <= STOP;
              end else begin
                case (idx_q)
                  3'd0: tx_q <= {3'b000, addr_q[12:8]};
                  3'd1: tx_q <= addr_q[7:0];
                  3'd2: if (we_q) tx_q <= wdata_q; else state_q <= RSTART;
                  3'd4: state_q <= RX_BYTE;
                  default: state_q <= STOP;
                endcase
              end
            end
            RSTART: begin
              state_q <= TX_BYTE;
              tx_q    <= 8'hA1;
              idx_q   <= 3'd4;
              bit_q   <= 4'd0;
            end
            RX_BYTE: begin
              bit_q <= bit_q + 4'd1;
              if (bit_q == 4'd7) state_q <= RX_NACK;
            end
            RX_NACK: state_q <= STOP;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign ack_err = ack_err_q;
  assign scl     = scl_q;
  assign sda_out = sda_q;
endmodule
